// File: rtl/sopc_data_bus.sv
// sopc_data_bus: data-side interconnect between the CPU data port and N_SLAVES
// variable-latency slaves.
//
// The top REGION_BITS address bits select the slave. The request is latched
// and presented to that slave, and the CPU is stalled until the slave acks.
// A decode miss or an ack timeout ends the transfer with a one-cycle bus error.
//
// Ports:
//   clk, rst       clock (rising edge), asynchronous active-low reset
//   m_ce_i         CPU request valid, held while m_stall_o is high
//   m_we_i         1 = write, 0 = read
//   m_addr_i       byte address
//   m_sel_i        byte enables
//   m_data_i       write data
//   m_data_o       read data, valid in the DONE/ERR cycle
//   m_stall_o      CPU must hold its request
//   m_err_o        one-cycle bus error pulse
//   s_ce_o         one-hot slave select
//   s_we_o         latched write flag
//   s_addr_o       latched address
//   s_sel_o        latched byte enables
//   s_data_o       latched write data
//   s_data_i       slave read data; slave k at bits [k*DATA_W +: DATA_W]
//   s_ack_i        slave completion, one bit per slave
//
// Optional macro SOPC_BUS_STATS_EN adds saturating statistics counters:
//   stat_xfer_o    completed transfers (DONE entries)
//   stat_err_o     bus error pulses
//   stat_wait_o    cycles with m_stall_o high
//   stat_clr_i     synchronous clear, wins over a same-cycle increment
module sopc_data_bus #(
    parameter int              DATA_W      = 32,
    parameter int              ADDR_W      = 32,
    parameter int              N_SLAVES    = 4,
    parameter int              REGION_BITS = 4,
    parameter int              TIMEOUT     = 255,
    parameter logic [DATA_W-1:0] ERR_DATA  = 32'hDEADBEEF,
    localparam int             SEL_W       = DATA_W / 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       m_ce_i,
    input  logic                       m_we_i,
    input  logic [ADDR_W-1:0]          m_addr_i,
    input  logic [SEL_W-1:0]           m_sel_i,
    input  logic [DATA_W-1:0]          m_data_i,
    output logic [DATA_W-1:0]          m_data_o,
    output logic                       m_stall_o,
    output logic                       m_err_o,
`ifdef SOPC_BUS_STATS_EN
    output logic [31:0]                stat_xfer_o,
    output logic [15:0]                stat_err_o,
    output logic [31:0]                stat_wait_o,
    input  logic                       stat_clr_i,
`endif
    output logic [N_SLAVES-1:0]        s_ce_o,
    output logic                       s_we_o,
    output logic [ADDR_W-1:0]          s_addr_o,
    output logic [SEL_W-1:0]           s_sel_o,
    output logic [DATA_W-1:0]          s_data_o,
    input  logic [N_SLAVES*DATA_W-1:0] s_data_i,
    input  logic [N_SLAVES-1:0]        s_ack_i
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [REGION_BITS:0] NS_LIM = (REGION_BITS + 1)'(N_SLAVES);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DONE,
        ERR
    } state_t;

    state_t                 state;
    logic [REGION_BITS-1:0] idx_q;
    logic [CNT_W-1:0]       cnt;
    logic                   orphan;

    logic [REGION_BITS-1:0] req_idx;
    logic                   req_hit;
    logic [N_SLAVES-1:0]    req_onehot;
    logic                   ack_sel;
    logic [DATA_W-1:0]      rdata_sel;
    logic                   timeout_hit;
    logic                   drop;

    assign req_idx = m_addr_i[ADDR_W-1 -: REGION_BITS];
    assign req_hit = ({1'b0, req_idx} < NS_LIM);

    // Select the acking slave by the latched index; acks from others are ignored.
    always_comb begin
        req_onehot = '0;
        ack_sel    = 1'b0;
        rdata_sel  = '0;
        for (int k = 0; k < N_SLAVES; k++) begin
            if (req_idx == REGION_BITS'(k)) begin
                req_onehot[k] = 1'b1;
            end
            if (idx_q == REGION_BITS'(k)) begin
                ack_sel   = s_ack_i[k];
                rdata_sel = s_data_i[k*DATA_W +: DATA_W];
            end
        end
    end

    // The counter holds the number of REQ cycles already spent, so this is
    // the cycle in which it reaches TIMEOUT.
    assign timeout_hit = (cnt >= TO_LAST);

    // The CPU counts as gone if it dropped the request earlier or drops it now.
    assign drop = orphan | ~m_ce_i;

    assign m_stall_o = m_ce_i && (state != DONE) && (state != ERR);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            idx_q    <= '0;
            cnt      <= '0;
            orphan   <= 1'b0;
            m_data_o <= '0;
            m_err_o  <= 1'b0;
            s_ce_o   <= '0;
            s_we_o   <= 1'b0;
            s_addr_o <= '0;
            s_sel_o  <= '0;
            s_data_o <= '0;
        end else begin
            m_err_o <= 1'b0;
            unique case (state)
                IDLE: begin
                    orphan <= 1'b0;
                    if (m_ce_i) begin
                        s_we_o   <= m_we_i;
                        s_addr_o <= m_addr_i;
                        s_sel_o  <= m_sel_i;
                        s_data_o <= m_data_i;
                        idx_q    <= req_idx;
                        cnt      <= '0;
                        if (req_hit) begin
                            state  <= REQ;
                            s_ce_o <= req_onehot;
                        end else begin
                            state   <= ERR;
                            m_err_o <= 1'b1;
                            if (!m_we_i) begin
                                m_data_o <= ERR_DATA;
                            end
                        end
                    end
                end
                REQ: begin
                    if (cnt != '1) begin
                        cnt <= cnt + 1'b1;
                    end
                    if (!m_ce_i) begin
                        orphan <= 1'b1;
                    end
                    if (ack_sel) begin
                        s_ce_o <= '0;
                        if (!s_we_o) begin
                            m_data_o <= rdata_sel;
                        end
                        if (drop) begin
                            state  <= IDLE;
                            orphan <= 1'b0;
                        end else begin
                            state <= DONE;
                        end
                    end else if (timeout_hit) begin
                        s_ce_o <= '0;
                        if (drop) begin
                            state  <= IDLE;
                            orphan <= 1'b0;
                        end else begin
                            state   <= ERR;
                            m_err_o <= 1'b1;
                            if (!s_we_o) begin
                                m_data_o <= ERR_DATA;
                            end
                        end
                    end
                end
                DONE, ERR: begin
                    state  <= IDLE;
                    orphan <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef SOPC_BUS_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_xfer_o <= '0;
            stat_err_o  <= '0;
            stat_wait_o <= '0;
        end else if (stat_clr_i) begin
            stat_xfer_o <= '0;
            stat_err_o  <= '0;
            stat_wait_o <= '0;
        end else begin
            if (state == DONE && stat_xfer_o != '1) begin
                stat_xfer_o <= stat_xfer_o + 1'b1;
            end
            if (m_err_o && stat_err_o != '1) begin
                stat_err_o <= stat_err_o + 1'b1;
            end
            if (m_stall_o && stat_wait_o != '1) begin
                stat_wait_o <= stat_wait_o + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_sopc_data_bus.sv
// tb_sopc_data_bus: self-checking bench for sopc_data_bus.
// Table vectors, hand-written reset/orphan sequences, random transfers vs. a model.
module tb_sopc_data_bus;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int NS = 4;
    localparam int RB = 4;
    localparam int TO = 8;
    localparam int SW = DW / 8;
    localparam logic [31:0] ERRD = 32'hDEADBEEF;

    logic             clk = 1'b0;
    logic             rst;
    logic             m_ce_i;
    logic             m_we_i;
    logic [AW-1:0]    m_addr_i;
    logic [SW-1:0]    m_sel_i;
    logic [DW-1:0]    m_data_i;
    logic [DW-1:0]    m_data_o;
    logic             m_stall_o;
    logic             m_err_o;
    logic [NS-1:0]    s_ce_o;
    logic             s_we_o;
    logic [AW-1:0]    s_addr_o;
    logic [SW-1:0]    s_sel_o;
    logic [DW-1:0]    s_data_o;
    logic [NS*DW-1:0] s_data_i;
    logic [NS-1:0]    s_ack_i;
`ifdef SOPC_BUS_STATS_EN
    logic [31:0]      stat_xfer_o;
    logic [15:0]      stat_err_o;
    logic [31:0]      stat_wait_o;
    logic             stat_clr_i;
`endif

    sopc_data_bus #(
        .DATA_W(DW),
        .ADDR_W(AW),
        .N_SLAVES(NS),
        .REGION_BITS(RB),
        .TIMEOUT(TO),
        .ERR_DATA(ERRD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .m_ce_i(m_ce_i),
        .m_we_i(m_we_i),
        .m_addr_i(m_addr_i),
        .m_sel_i(m_sel_i),
        .m_data_i(m_data_i),
        .m_data_o(m_data_o),
        .m_stall_o(m_stall_o),
        .m_err_o(m_err_o),
`ifdef SOPC_BUS_STATS_EN
        .stat_xfer_o(stat_xfer_o),
        .stat_err_o(stat_err_o),
        .stat_wait_o(stat_wait_o),
        .stat_clr_i(stat_clr_i),
`endif
        .s_ce_o(s_ce_o),
        .s_we_o(s_we_o),
        .s_addr_o(s_addr_o),
        .s_sel_o(s_sel_o),
        .s_data_o(s_data_o),
        .s_data_i(s_data_i),
        .s_ack_i(s_ack_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          delay;
        int          e_stall;
        int          e_req;
        logic        e_err;
        logic [31:0] e_data;
        logic [3:0]  e_ce;
    } vec_t;

    int n_chk = 0;
    int n_pass = 0;
    logic [31:0] last_exp;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Transfer-level prediction: a decode miss errors at once; a hit
    // completes after delay+1 REQ cycles unless that exceeds TIMEOUT.
    function automatic vec_t predict(input vec_t v, input logic [31:0] last);
        vec_t r;
        int ti;
        r  = v;
        ti = int'(v.addr[31:28]);
        r.e_ce = '0;
        if (ti >= NS) begin
            r.e_req   = 0;
            r.e_stall = 1;
            r.e_err   = 1'b1;
            r.e_data  = v.we ? last : ERRD;
        end else begin
            r.e_ce = 4'(1 << ti);
            if (v.delay + 1 <= TO) begin
                r.e_req   = v.delay + 1;
                r.e_stall = v.delay + 2;
                r.e_err   = 1'b0;
                r.e_data  = v.we ? last : v.rdata;
            end else begin
                r.e_req   = TO;
                r.e_stall = TO + 1;
                r.e_err   = 1'b1;
                r.e_data  = v.we ? last : ERRD;
            end
        end
        return r;
    endfunction

    // One CPU transfer with a slave that acks in REQ cycle delay+1.
    // Unselected slaves toggle random acks, which must be ignored.
    task automatic xfer(input vec_t v, input string tag);
        int          stall_n;
        int          req_n;
        int          ti;
        logic        done;
        logic        err_early;
        logic        s_bad;
        logic        fin_err;
        logic [31:0] fin_data;
        logic [3:0]  ce_seen;
        @(negedge clk);
        m_ce_i   = 1'b1;
        m_we_i   = v.we;
        m_addr_i = v.addr;
        m_sel_i  = v.sel;
        m_data_i = v.wdata;
        s_ack_i  = '0;
        for (int k = 0; k < NS; k++) begin
            s_data_i[k*DW +: DW] = $urandom;
        end
        ti = int'(v.addr[31:28]);
        if (ti < NS) begin
            s_data_i[ti*DW +: DW] = v.rdata;
        end
        stall_n   = 0;
        req_n     = 0;
        done      = 1'b0;
        err_early = 1'b0;
        s_bad     = 1'b0;
        fin_err   = 1'b0;
        fin_data  = '0;
        ce_seen   = '0;
        for (int c = 0; c < 60 && !done; c++) begin
            if (s_ce_o != '0) begin
                req_n++;
                ce_seen = ce_seen | s_ce_o;
                if (s_we_o !== v.we || s_addr_o !== v.addr ||
                    s_sel_o !== v.sel || s_data_o !== v.wdata) begin
                    s_bad = 1'b1;
                end
                s_ack_i = (4'($urandom) & ~s_ce_o) |
                          ((req_n == v.delay + 1) ? s_ce_o : 4'b0);
            end else begin
                s_ack_i = '0;
            end
            #1;
            if (m_stall_o) begin
                stall_n++;
                if (m_err_o) begin
                    err_early = 1'b1;
                end
                @(negedge clk);
            end else begin
                done     = 1'b1;
                fin_err  = m_err_o;
                fin_data = m_data_o;
            end
        end
        chk({tag, "_finished"}, 32'(done), 32'd1);
        chk({tag, "_stall_cycles"}, 32'(stall_n), 32'(v.e_stall));
        chk({tag, "_req_cycles"}, 32'(req_n), 32'(v.e_req));
        chk({tag, "_slave_sel"}, 32'(ce_seen), 32'(v.e_ce));
        chk({tag, "_slave_fields"}, 32'(s_bad), 32'd0);
        chk({tag, "_err_early"}, 32'(err_early), 32'd0);
        chk({tag, "_err"}, 32'(fin_err), 32'(v.e_err));
        chk({tag, "_rdata"}, fin_data, v.e_data);
        @(negedge clk);
        m_ce_i  = 1'b0;
        s_ack_i = '0;
        #1;
        chk({tag, "_err_after"}, 32'(m_err_o), 32'd0);
        chk({tag, "_stall_after"}, 32'(m_stall_o), 32'd0);
    endtask

    vec_t tbl[7];
    vec_t v;

    initial begin
`ifdef SOPC_BUS_STATS_EN
        logic [31:0] xfer0;
        stat_clr_i = 1'b0;
`endif
        rst      = 1'b0;
        m_ce_i   = 1'b0;
        m_we_i   = 1'b0;
        m_addr_i = '0;
        m_sel_i  = '0;
        m_data_i = '0;
        s_data_i = '0;
        s_ack_i  = '0;
        #1;
        chk("reset_stall", 32'(m_stall_o), 32'd0);
        chk("reset_ce", 32'(s_ce_o), 32'd0);
        chk("reset_err", 32'(m_err_o), 32'd0);
        chk("reset_rdata", m_data_o, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        //        addr          we    sel    wdata         rdata         dly stall req err   data          ce
        tbl[0] = '{32'h1000_0010, 1'b0, 4'hF, 32'h0,        32'h1234_5678, 0, 2, 1, 1'b0, 32'h1234_5678, 4'b0010};
        tbl[1] = '{32'h2000_0004, 1'b1, 4'h3, 32'hCAFE_F00D, 32'h5555_AAAA, 3, 5, 4, 1'b0, 32'h1234_5678, 4'b0100};
        tbl[2] = '{32'h5000_0000, 1'b0, 4'hF, 32'h0,        32'h0,         0, 1, 0, 1'b1, 32'hDEAD_BEEF, 4'b0000};
        tbl[3] = '{32'h0000_0000, 1'b0, 4'hF, 32'h0,        32'h1111_2222, 99, 9, 8, 1'b1, 32'hDEAD_BEEF, 4'b0001};
        tbl[4] = '{32'h0000_0040, 1'b0, 4'hF, 32'h0,        32'hA5A5_0001, 7, 9, 8, 1'b0, 32'hA5A5_0001, 4'b0001};
        tbl[5] = '{32'hF000_0000, 1'b1, 4'hF, 32'h0BAD_0BAD, 32'h0,        0, 1, 0, 1'b1, 32'hA5A5_0001, 4'b0000};
        tbl[6] = '{32'h3000_0008, 1'b0, 4'hC, 32'h0,        32'h0BAD_F00D, 1, 3, 2, 1'b0, 32'h0BAD_F00D, 4'b1000};
        for (int i = 0; i < 7; i++) begin
            xfer(tbl[i], $sformatf("vec%0d", i));
        end

        // Asynchronous reset in the middle of a REQ phase.
        @(negedge clk);
        m_ce_i   = 1'b1;
        m_we_i   = 1'b0;
        m_addr_i = 32'h2000_0000;
        s_ack_i  = '0;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rstmid_pre_ce", 32'(s_ce_o), 32'b0100);
        #2;
        rst = 1'b0;
        #1;
        chk("rstmid_ce_async", 32'(s_ce_o), 32'd0);
        chk("rstmid_rdata", m_data_o, 32'd0);
        m_ce_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rstmid_idle_stall", 32'(m_stall_o), 32'd0);

        // Orphaned read to slave 1, then a fresh read to slave 3.
`ifdef SOPC_BUS_STATS_EN
        xfer0 = stat_xfer_o;
`endif
        @(negedge clk);
        m_ce_i   = 1'b1;
        m_we_i   = 1'b0;
        m_addr_i = 32'h1000_0000;
        m_sel_i  = 4'hF;
        s_ack_i  = '0;
        s_data_i = {32'h7777_8888, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
        @(negedge clk);
        #1;
        chk("orph_req_ce", 32'(s_ce_o), 32'b0010);
        @(negedge clk);
        m_ce_i = 1'b0;
        #1;
        chk("orph_drop_stall", 32'(m_stall_o), 32'd0);
        @(negedge clk);
        m_ce_i   = 1'b1;
        m_addr_i = 32'h3000_0000;
        #1;
        chk("orph_new_stall", 32'(m_stall_o), 32'd1);
        chk("orph_old_addr", s_addr_o, 32'h1000_0000);
        @(negedge clk);
        s_ack_i = 4'b0010;
        #1;
        chk("orph_ack_stall", 32'(m_stall_o), 32'd1);
        @(negedge clk);
        s_ack_i = '0;
        #1;
        chk("orph_idle_stall", 32'(m_stall_o), 32'd1);
        chk("orph_idle_ce", 32'(s_ce_o), 32'd0);
        chk("orph_idle_err", 32'(m_err_o), 32'd0);
        @(negedge clk);
        #1;
        chk("orph_new_ce", 32'(s_ce_o), 32'b1000);
        chk("orph_new_addr", s_addr_o, 32'h3000_0000);
        s_ack_i = 4'b1000;
        @(negedge clk);
        s_ack_i = '0;
        #1;
        chk("orph_done_stall", 32'(m_stall_o), 32'd0);
        chk("orph_done_rdata", m_data_o, 32'h7777_8888);
        chk("orph_done_err", 32'(m_err_o), 32'd0);
        @(negedge clk);
        m_ce_i = 1'b0;
        #1;
`ifdef SOPC_BUS_STATS_EN
        chk("stat_xfer_inc", stat_xfer_o, xfer0 + 32'd1);
        stat_clr_i = 1'b1;
        @(negedge clk);
        stat_clr_i = 1'b0;
        #1;
        chk("stat_clr", stat_xfer_o, 32'd0);
`endif
        last_exp = 32'h7777_8888;

        for (int i = 0; i < 40; i++) begin
            int ti;
            ti       = $urandom_range(0, 5);
            v.addr   = (32'(ti) << 28) | ($urandom & 32'h0FFF_FFFC);
            v.we     = 1'($urandom_range(0, 1));
            v.sel    = 4'($urandom);
            v.wdata  = $urandom;
            v.rdata  = $urandom;
            v.delay  = $urandom_range(0, 10);
            v = predict(v, last_exp);
            xfer(v, $sformatf("rnd%0d", i));
            last_exp = v.e_data;
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/sopc_data_bus.md
Name: sopc_data_bus

Overview:
- Parametrised data-side interconnect between the CPU data port (ram_* signals) and N_SLAVES memory/peripheral slaves with variable latency.
- Decodes the address region, forwards a registered request, stalls the CPU until the slave acks, and returns the read data.
- Signals a bus error on a decode miss or an ack timeout.
- Replaces the direct CPU-to-data_ram wiring in the SOPC top.

Parameters:
DATA_W, 32, data width; SEL_W = DATA_W/8 (derived, byte enables)
ADDR_W, 32, address width
N_SLAVES, 4, number of slave channels (1..16)
REGION_BITS, 4, top address bits used as slave index
TIMEOUT, 255, max REQ cycles waiting for ack before error (>=1)
ERR_DATA, 32'hDEADBEEF, read data returned on error

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
m_ce_i  in  1  CPU request valid (held while m_stall_o=1)
m_we_i  in  1  1=write, 0=read
m_addr_i  in  ADDR_W  byte address
m_sel_i  in  SEL_W  byte enables
m_data_i  in  DATA_W  write data
m_data_o  out  DATA_W  read data, valid in the DONE/ERR cycle
m_stall_o  out  1  CPU must hold request
m_err_o  out  1  one-cycle bus error pulse
s_ce_o  out  N_SLAVES  one-hot slave select
s_we_o  out  1  latched write flag
s_addr_o  out  ADDR_W  latched address
s_sel_o  out  SEL_W  latched byte enables
s_data_o  out  DATA_W  latched write data
s_data_i  in  N_SLAVES*DATA_W  slave read data, slave k at bits [k*DATA_W +: DATA_W]
s_ack_i  in  N_SLAVES  slave completion, one bit per slave

Behaviour:
- Reset (rst=0, async): state=IDLE; all registered outputs 0; m_data_o=0; timeout counter=0; orphan=0. s_ce_o drops immediately, even mid-transfer.
- Decode: idx = m_addr_i[ADDR_W-1 -: REGION_BITS]; hit iff idx < N_SLAVES.
- m_stall_o = m_ce_i && state not in {DONE, ERR}. This is combinational, so it is high in the request's first IDLE cycle.
- IDLE, m_ce_i=1:
  - Latch we/addr/sel/data and idx.
  - Hit: go to REQ, s_ce_o[idx]=1 from the next cycle.
  - Miss: go to ERR; no slave is touched.
- REQ:
  - s_ce_o and s_* are held constant.
  - Counter increments each cycle.
  - s_ack_i[idx]=1: read latches s_data_i[idx] into m_data_o; go to DONE, or IDLE if orphan.
  - Counter reaches TIMEOUT without ack: go to ERR, or IDLE if orphan.
  - Acks from non-selected slaves are ignored.
- DONE: one cycle; s_ce_o=0; stall released; m_data_o holds read data; writes leave m_data_o unchanged. Next state IDLE.
- ERR: one cycle; s_ce_o=0; m_err_o=1 only if not orphan; read sets m_data_o=ERR_DATA. Next state IDLE.
- Minimum latency:
  - Ack in first REQ cycle: request seen in cycle 0, REQ in cycle 1, DONE in cycle 2; CPU stalls 2 cycles.
  - Decode miss: ERR in cycle 1.
- Back-to-back requests: a new request is accepted only from IDLE, so there is at least one idle cycle between transfers.
- Orphan (flush):
  - m_ce_i=0 in any REQ cycle sets orphan. The transaction still completes on the slave side.
  - Completion returns to IDLE with no DONE/ERR and no m_err_o.
  - A new m_ce_i arriving meanwhile stays stalled until IDLE, then starts fresh.
  - orphan clears on entering IDLE.
- Ack and timeout in the same cycle: ack wins.
- Timeout counter is width clog2(TIMEOUT+1), cleared on entry to REQ, and saturates (no wrap).

Optional Feature:
SOPC_BUS_STATS_EN
- Defined:
  - Adds ports stat_xfer_o (32, out), stat_err_o (16, out), stat_wait_o (32, out) and stat_clr_i (1, in, synchronous clear).
  - stat_xfer_o counts DONE entries. stat_err_o counts m_err_o pulses. stat_wait_o counts cycles with m_stall_o=1.
  - All counters saturate at max. All reset to 0 on rst.
  - stat_clr_i has priority over a same-cycle increment.
- Undefined: these ports and counters do not exist; the remaining behaviour is identical.

Test Plan:
- Reset mid-REQ: assert rst=0 asynchronously -> s_ce_o=0 before the next clk edge; after release, state is IDLE and m_stall_o=0 with m_ce_i=0.
- Read slave 1 at 0x1000_0010, ack on first REQ cycle, s_data_i slice 1=0x12345678 -> s_ce_o=4'b0010 for 1 cycle, m_stall_o high 2 cycles, m_data_o=0x12345678 in the DONE cycle, m_err_o=0.
- Write 0x2000_0004, sel=4'b0011, data 0xCAFEF00D, slave 2 acks after 3 wait cycles -> s_we_o=1, s_sel_o=4'b0011, s_data_o=0xCAFEF00D stable 4 cycles, then DONE; m_data_o unchanged.
- Read 0x5000_0000 (idx 5 >= N_SLAVES=4) -> no s_ce_o bit set, ERR next cycle, m_err_o 1-cycle pulse, m_data_o=0xDEADBEEF.
- Read slave 0 with TIMEOUT=8 and no ack -> REQ for 8 cycles, then ERR with m_err_o=1 and m_data_o=0xDEADBEEF. Repeat with ack in the cycle the counter reaches 8 -> DONE, no error.
- Orphan: drop m_ce_i in cycle 2 of REQ, raise a new read to slave 3, old slave acks -> no DONE and no m_err_o for the old transfer; new request stalls until IDLE, then completes with slave 3 data. With SOPC_BUS_STATS_EN, stat_xfer_o increments by exactly 1.
